// File: rtl/alu_op_sequencer.sv
// ALU operation sequencer: forwards ops 0-9 to an external combinational ALU,
// and runs a radix-2 Booth multiplier (op 10) and, optionally, a restoring
// unsigned divider (op 11) internally. One request is in flight at a time.
// Defining ALU_SEQ_DIV_EN builds the divider; without it op 11 is illegal.
module alu_op_sequencer #(
  parameter logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_cntrl,
  input  logic [31:0] alu_c,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_lo,
  output logic [31:0] rsp_hi,
  output logic        rsp_err,
  output logic        busy
);

  typedef enum logic [2:0] {
    StIdle,
    StAlu,
    StMul,
    StDiv,
    StDone
  } state_e;

  localparam logic [3:0] OpLastAlu = 4'd9;
  localparam logic [3:0] OpMul     = 4'd10;
`ifdef ALU_SEQ_DIV_EN
  localparam logic [3:0] OpDiv     = 4'd11;
`endif

  state_e      state_q, state_d;
  logic [4:0]  cnt_q;
  logic [3:0]  op_q;
  logic [31:0] a_q, b_q;

  // Shared iterative datapath. For multiply: acc_q is the 33-bit partial
  // product, sh_q the multiplier, q1_q the Booth guard bit and m_q the
  // sign-extended multiplicand. For divide: acc_q[31:0] is the remainder,
  // sh_q the dividend shifting into quotient and m_q the zero-extended divisor.
  logic [32:0] acc_q;
  logic [31:0] sh_q;
  logic        q1_q;
  logic [32:0] m_q;

  logic [31:0] lo_q, hi_q;
  logic        err_q;

  logic        last_iter;
  assign last_iter = (cnt_q == 5'd31);

  // Booth step: add/subtract the multiplicand, then arithmetic shift right
  logic [32:0] booth_sum;
  logic [32:0] booth_acc;
  logic [31:0] booth_sh;
  logic        booth_q1;

  // Booth add/subtract selection from the current multiplier bit pair
  always_comb begin
    booth_sum = acc_q;
    case ({sh_q[0], q1_q})
      2'b01:   booth_sum = acc_q + m_q;
      2'b10:   booth_sum = acc_q - m_q;
      default: booth_sum = acc_q;
    endcase
  end

  assign booth_acc = {booth_sum[32], booth_sum[32:1]};
  assign booth_sh  = {booth_sum[0], sh_q[31:1]};
  assign booth_q1  = sh_q[0];

`ifdef ALU_SEQ_DIV_EN
  // Restoring division step: shift in the next dividend bit and try a subtract
  logic [32:0] div_shift;
  logic [32:0] div_diff;
  logic [31:0] div_rem;
  logic [31:0] div_quo;

  // Trial subtraction; bit 32 of the difference is the borrow
  always_comb begin
    div_shift = {acc_q[31:0], sh_q[31]};
    div_diff  = div_shift - m_q;
    div_rem   = div_diff[32] ? div_shift[31:0] : div_diff[31:0];
    div_quo   = {sh_q[30:0], ~div_diff[32]};
  end
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (req_op <= OpLastAlu) begin
            state_d = StAlu;
          end else if (req_op == OpMul) begin
            state_d = StMul;
`ifdef ALU_SEQ_DIV_EN
          end else if ((req_op == OpDiv) && (req_b != '0)) begin
            state_d = StDiv;
`endif
          end else begin
            // Illegal ops and divide-by-zero answer immediately
            state_d = StDone;
          end
        end
      end
      StAlu: state_d = StDone;
      StMul: begin
        if (last_iter) begin
          state_d = StDone;
        end
      end
      StDiv: begin
`ifdef ALU_SEQ_DIV_EN
        if (last_iter) begin
          state_d = StDone;
        end
`else
        state_d = StIdle;
`endif
      end
      StDone: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Operand capture, iteration engine and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      sh_q  <= '0;
      q1_q  <= 1'b0;
      m_q   <= '0;
      lo_q  <= '0;
      hi_q  <= '0;
      err_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            op_q  <= req_op;
            a_q   <= req_a;
            b_q   <= req_b;
            cnt_q <= '0;
            acc_q <= '0;
            q1_q  <= 1'b0;
            lo_q  <= '0;
            hi_q  <= '0;
            err_q <= 1'b0;
            if (req_op == OpMul) begin
              sh_q <= req_b;
              m_q  <= {req_a[31], req_a};
`ifdef ALU_SEQ_DIV_EN
            end else if (req_op == OpDiv) begin
              if (req_b == '0) begin
                lo_q  <= DIV0_QUOT;
                hi_q  <= req_a;
                err_q <= 1'b1;
              end else begin
                sh_q <= req_a;
                m_q  <= {1'b0, req_b};
              end
`endif
            end else if (req_op > OpLastAlu) begin
              err_q <= 1'b1;
            end
          end
        end
        StAlu: begin
          lo_q <= alu_c;
          hi_q <= '0;
        end
        StMul: begin
          cnt_q <= cnt_q + 5'd1;
          acc_q <= booth_acc;
          sh_q  <= booth_sh;
          q1_q  <= booth_q1;
          if (last_iter) begin
            // The 65-bit {acc,sh} holds the product sign-extended by one bit
            lo_q <= booth_sh;
            hi_q <= booth_acc[31:0];
          end
        end
        StDiv: begin
`ifdef ALU_SEQ_DIV_EN
          cnt_q <= cnt_q + 5'd1;
          acc_q <= {1'b0, div_rem};
          sh_q  <= div_quo;
          if (last_iter) begin
            lo_q <= div_quo;
            hi_q <= div_rem;
          end
`endif
        end
        default: begin
        end
      endcase
    end
  end

  // Handshake, status and ALU drive outputs decoded from state
  always_comb begin
    req_ready = (state_q == StIdle);
    busy      = (state_q != StIdle);
    rsp_valid = (state_q == StDone);
    alu_a     = '0;
    alu_b     = '0;
    alu_cntrl = '0;
    if (state_q == StAlu) begin
      alu_a     = a_q;
      alu_b     = b_q;
      alu_cntrl = op_q;
    end
  end

  assign rsp_lo  = lo_q;
  assign rsp_hi  = hi_q;
  assign rsp_err = err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: directed cases plus randomized ops,
// random response back-pressure and ignored requests while busy. Expected
// responses come from a behavioural model using plain arithmetic.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_a, req_b;
  logic [31:0] alu_a, alu_b, alu_c;
  logic [3:0]  alu_cntrl;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_lo, rsp_hi;
  logic        rsp_err;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        err;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];

  // Cycle in which an ALU op was accepted; the ALU ports are live one cycle later
  int          alu_win = -10;
  logic [31:0] win_a, win_b;
  logic [3:0]  win_op;

  alu_op_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_cntrl (alu_cntrl),
    .alu_c     (alu_c),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_lo    (rsp_lo),
    .rsp_hi    (rsp_hi),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // External ALU used by the environment
  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd3:    return a - b;
      4'd4:    return a ^ b;
      4'd5:    return a << b[4:0];
      4'd6:    return a >> b[4:0];
      4'd7:    return $unsigned($signed(a) >>> b[4:0]);
      4'd8:    return {31'd0, $signed(a) < $signed(b)};
      4'd9:    return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  assign alu_c = alu_fn(alu_cntrl, alu_a, alu_b);

  // Reference model of one operation's response
  function automatic void model(input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] lo,
                                output logic [31:0] hi, output logic err, output int lat);
    logic signed [63:0] p;
    lo  = 32'd0;
    hi  = 32'd0;
    err = 1'b1;
    lat = 1;
    if (op <= 4'd9) begin
      lo  = alu_fn(op, a, b);
      err = 1'b0;
      lat = 2;
    end else if (op == 4'd10) begin
      p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      {hi, lo} = p;
      err = 1'b0;
      lat = 33;
    end
`ifdef ALU_SEQ_DIV_EN
    else if (op == 4'd11) begin
      if (b == 32'd0) begin
        lo = 32'hFFFF_FFFF;
        hi = a;
      end else begin
        lo  = a / b;
        hi  = a % b;
        err = 1'b0;
        lat = 33;
      end
    end
`endif
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on each new response and watches outputs
  logic        in_rsp = 1'b0;
  logic        expect_idle = 1'b0;
  logic [31:0] cap_lo, cap_hi;
  logic        cap_err;
  exp_t        mon_e;

  always @(negedge clk) begin
    #1;
    if (rst) begin
      check("reset_ctrl", {rsp_valid, rsp_err, busy, req_ready}, 4'b0001);
      check("reset_rsp", {rsp_hi, rsp_lo}, 64'd0);
      check("reset_alu", {alu_cntrl, alu_a, alu_b}, 68'd0);
      in_rsp      = 1'b0;
      expect_idle = 1'b0;
    end else begin
      if (cyc == alu_win + 1) begin
        check("alu_ports_live", {alu_cntrl, alu_a, alu_b}, {win_op, win_a, win_b});
      end else begin
        check("alu_ports_zero", {alu_cntrl, alu_a, alu_b}, 68'd0);
      end
      if (expect_idle) begin
        check("done_to_idle", {rsp_valid, req_ready, busy}, 3'b010);
        expect_idle = 1'b0;
      end else if (rsp_valid) begin
        if (!in_rsp) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_rsp: got lo=%0h hi=%0h err=%0b expected none",
                     rsp_lo, rsp_hi, rsp_err);
          end else begin
            mon_e = sb.pop_front();
            check("rsp_lo", rsp_lo, mon_e.lo);
            check("rsp_hi", rsp_hi, mon_e.hi);
            check("rsp_err", rsp_err, mon_e.err);
            check("latency", cyc - mon_e.acc_cyc, mon_e.lat);
          end
          cap_lo  = rsp_lo;
          cap_hi  = rsp_hi;
          cap_err = rsp_err;
          in_rsp  = 1'b1;
        end else begin
          check("rsp_stable", {rsp_err, rsp_hi, rsp_lo}, {cap_err, cap_hi, cap_lo});
        end
        check("done_status", {busy, req_ready}, 2'b10);
        if (rsp_ready) begin
          in_rsp      = 1'b0;
          expect_idle = 1'b1;
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    alu_win   = -10;
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Issue one op from IDLE and drive the bus until the DUT is idle again
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit hold);
    exp_t e;
    logic [31:0] lo, hi;
    logic err;
    int lat, n, held;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    rsp_ready = 1'($urandom_range(0, 1));
    check("req_ready_idle", req_ready, 1'b1);
    model(op, a, b, lo, hi, err, lat);
    e.lo = lo;
    e.hi = hi;
    e.err = err;
    e.lat = lat;
    e.acc_cyc = cyc;
    sb.push_back(e);
    if (op <= 4'd9) begin
      alu_win = cyc;
      win_a   = a;
      win_b   = b;
      win_op  = op;
    end
    n = 0;
    held = 0;
    do begin
      @(negedge clk);
      n++;
      rsp_ready = 1'($urandom_range(0, 1));
      if (hold && rsp_valid) begin
        if (held < 5) begin
          rsp_ready = 1'b0;
          held++;
          check("held_req_ready", req_ready, 1'b0);
        end else begin
          rsp_ready = 1'b1;
        end
      end
      // Junk requests only where the DUT cannot reach IDLE on the next edge
      if (busy && (!rsp_valid || !rsp_ready)) begin
        req_valid = 1'($urandom_range(0, 1));
        req_op    = 4'($urandom);
        req_a     = $urandom;
        req_b     = $urandom;
      end else begin
        req_valid = 1'b0;
      end
    end while (!(req_ready && sb.size() == 0) && n < 200);
    if (n >= 200) begin
      n_checks++;
      n_errors++;
      $display("FAIL timeout: op %0d got no completed response within 200 cycles, required one",
               op);
      do_reset();
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op(4'd2, 32'd5, 32'd9, 1'b0);
    run_op(4'd10, 32'hFFFF_FFFD, 32'd7, 1'b0);
    run_op(4'd10, 32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op(4'd11, 32'd100, 32'd7, 1'b0);
    run_op(4'd11, 32'd55, 32'd0, 1'b0);
    run_op(4'd13, 32'd3, 32'd4, 1'b0);
    run_op(4'd10, 32'h1234_5678, 32'hFEDC_BA98, 1'b1);

    // Abort a multiply at iteration 10
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 4'd10;
    req_a     = 32'h0000_1234;
    req_b     = 32'h0000_5678;
    acc       = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    while (cyc < acc + 11) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    alu_win = -10;
    @(negedge clk);
    rst = 1'b0;
    run_op(4'd0, 32'h0000_00F0, 32'h0000_003C, 1'b0);

    for (int i = 0; i < 80; i++) begin
      logic [3:0] op;
      case ($urandom_range(0, 5))
        0, 1:    op = 4'($urandom_range(0, 9));
        2:       op = 4'd10;
        3, 4:    op = 4'd11;
        default: op = 4'($urandom_range(12, 15));
      endcase
      run_op(op, pick_operand(), pick_operand(), ($urandom_range(0, 9) == 0));
    end

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL leftover_responses: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
